// File: rtl/idex_pkg.sv
// Shared ID/EX definitions: widths, NOP/bubble encodings, control bundle layout.
// Pure types and constants, no latency or flow control.
package idex_pkg;

  localparam int DATA_W  = 16;
  localparam int REG_W   = 3;
  localparam int CTRL_W  = 10;

  localparam logic [DATA_W-1:0] INSTR_NOP = 16'h0800;

  // Control bit positions, MSB first.
  localparam int CTRL_REGDST_HI  = 9;
  localparam int CTRL_REGDST_LO  = 8;
  localparam int CTRL_REGWRITE   = 7;
  localparam int CTRL_DMEMEN     = 6;
  localparam int CTRL_DMEMWRITE  = 5;
  localparam int CTRL_MEMTOREG   = 4;
  localparam int CTRL_ALUSRC2    = 3;
  localparam int CTRL_SET        = 2;
  localparam int CTRL_LBI        = 1;
  localparam int CTRL_PCIMM      = 0;

  typedef struct packed {
    logic [1:0] reg_dst;
    logic       reg_write;
    logic       dmem_en;
    logic       dmem_write;
    logic       mem_to_reg;
    logic       alu_src2;
    logic       set;
    logic       lbi;
    logic       pc_imm;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] pc2;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    ctrl_t             ctrl;
    logic              valid;
  } idex_t;

  localparam idex_t IDEX_BUBBLE = '{
    instr:   INSTR_NOP,
    pc2:     '0,
    rs_data: '0,
    rt_data: '0,
    ctrl:    CTRL_BUBBLE,
    valid:   1'b0
  };

  function automatic logic [REG_W-1:0] rs_idx(input logic [DATA_W-1:0] instr);
    return instr[10:8];
  endfunction

  function automatic logic [REG_W-1:0] rt_idx(input logic [DATA_W-1:0] instr);
    return instr[7:5];
  endfunction

endpackage

// File: rtl/idex_bypass.sv
// Writeback-to-operand bypass mux: picks wb_data when writeback targets reg_idx.
// Combinational, zero latency, no flow control.
module idex_bypass
  import idex_pkg::*;
(
  input  logic [REG_W-1:0]  reg_idx,
  input  logic [DATA_W-1:0] operand,
  input  logic              wb_we,
  input  logic [REG_W-1:0]  wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] sel_data
);

  always_comb begin
    sel_data = operand;
    if (wb_we && (wb_reg == reg_idx)) begin
      sel_data = wb_data;
    end
  end

endmodule

// File: rtl/idex_latch.sv
// ID/EX pipeline register with flush/hold/bubble and WB bypass; 1-cycle load latency.
// Holds on exex_stall|mem_stall (hold_ex, combinational); IDEX_PERF_CNT_EN adds hold/flush counters.
module idex_latch
  import idex_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] instr_id,
  input  logic [DATA_W-1:0] pc2_id,
  input  logic [DATA_W-1:0] rs_data_id,
  input  logic [DATA_W-1:0] rt_data_id,
  input  logic [CTRL_W-1:0] ctrl_id,
  input  logic              valid_id,
  input  logic              exex_stall,
  input  logic              mem_stall,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [REG_W-1:0]  wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] instr_ex,
  output logic [DATA_W-1:0] pc2_ex,
  output logic [DATA_W-1:0] rs_data_ex,
  output logic [DATA_W-1:0] rt_data_ex,
  output logic [CTRL_W-1:0] ctrl_ex,
  output logic              valid_ex,
`ifdef IDEX_PERF_CNT_EN
  output logic [15:0]       hold_cnt,
  output logic [15:0]       flush_cnt,
`endif
  output logic              hold_ex
);

  idex_t idex_q, idex_d;

  logic [DATA_W-1:0] ld_rs_data, ld_rt_data;
  logic [DATA_W-1:0] rf_rs_data, rf_rt_data;

  assign hold_ex = exex_stall | mem_stall;

  idex_bypass u_ld_rs (
    .reg_idx  (rs_idx(instr_id)),
    .operand  (rs_data_id),
    .wb_we    (wb_we),
    .wb_reg   (wb_reg),
    .wb_data  (wb_data),
    .sel_data (ld_rs_data)
  );

  idex_bypass u_ld_rt (
    .reg_idx  (rt_idx(instr_id)),
    .operand  (rt_data_id),
    .wb_we    (wb_we),
    .wb_reg   (wb_reg),
    .wb_data  (wb_data),
    .sel_data (ld_rt_data)
  );

  // Refresh paths keep held operands current while execute is stalled.
  idex_bypass u_rf_rs (
    .reg_idx  (rs_idx(idex_q.instr)),
    .operand  (idex_q.rs_data),
    .wb_we    (wb_we),
    .wb_reg   (wb_reg),
    .wb_data  (wb_data),
    .sel_data (rf_rs_data)
  );

  idex_bypass u_rf_rt (
    .reg_idx  (rt_idx(idex_q.instr)),
    .operand  (idex_q.rt_data),
    .wb_we    (wb_we),
    .wb_reg   (wb_reg),
    .wb_data  (wb_data),
    .sel_data (rf_rt_data)
  );

  always_comb begin
    idex_d = idex_q;
    if (flush) begin
      idex_d = IDEX_BUBBLE;
    end else if (hold_ex) begin
      if (idex_q.valid) begin
        idex_d.rs_data = rf_rs_data;
        idex_d.rt_data = rf_rt_data;
      end
    end else if (!valid_id) begin
      idex_d = IDEX_BUBBLE;
    end else begin
      idex_d.instr   = instr_id;
      idex_d.pc2     = pc2_id;
      idex_d.rs_data = ld_rs_data;
      idex_d.rt_data = ld_rt_data;
      idex_d.ctrl    = ctrl_t'(ctrl_id);
      idex_d.valid   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q <= IDEX_BUBBLE;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign instr_ex   = idex_q.instr;
  assign pc2_ex     = idex_q.pc2;
  assign rs_data_ex = idex_q.rs_data;
  assign rt_data_ex = idex_q.rt_data;
  assign ctrl_ex    = idex_q.ctrl;
  assign valid_ex   = idex_q.valid;

`ifdef IDEX_PERF_CNT_EN
  logic [15:0] hold_cnt_q, hold_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    hold_cnt_d  = hold_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hold_ex && !flush && (hold_cnt_q != 16'hFFFF)) begin
      hold_cnt_d = hold_cnt_q + 16'd1;
    end
    if (flush && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_q  <= '0;
      flush_cnt_q <= '0;
    end else begin
      hold_cnt_q  <= hold_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hold_cnt  = hold_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
